bldc_ramp_sequencer: RTL

- APB2 master that sequences the BLDC peripheral through start-up, duty ramp, steady run, stop and fault shutdown.
- Sits between the system control logic (start/stop/target commands) and the BLDC peripheral's APB2 slave port, in the `pclk` domain.
- Issues control and PWM-duty register writes, and polls the status register between ramp steps.
- Shuts the drive down on fault, hall error, bus error or bus timeout.

---
 rtl/bldc_ramp_sequencer_pkg.sv | 40 ++++
 rtl/bldc_ramp_sequencer_if.sv | 29 ++
 rtl/bldc_ramp_sequencer_apb2_master_port.sv | 147 ++++++++++++++
 rtl/bldc_ramp_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_ramp_sequencer_pkg.sv
// bldc_seq_pkg: shared constants and types for the BLDC ramp sequencer.
//   - APB register addresses of the BLDC peripheral
//   - status register bit indices
//   - fault_code bit positions
//   - sequencer and APB-engine state encodings
package bldc_seq_pkg;

  // Slave register map (byte addresses)
  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_CTRL   = 8'h10;
  localparam logic [7:0] REG_PWM    = 8'h14;

  // Status register bits
  localparam int STAT_HALL_BIT  = 14;
  localparam int STAT_FAULT_BIT = 15;

  // fault_code bit positions
  localparam int FC_STATUS  = 0;
  localparam int FC_SLVERR  = 1;
  localparam int FC_TIMEOUT = 2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_DUTY0 = 4'd1,
    S_WR_EN    = 4'd2,
    S_WAIT     = 4'd3,
    S_RD_STAT  = 4'd4,
    S_WR_STEP  = 4'd5,
    S_SD_DUTY  = 4'd6,
    S_SD_CTL   = 4'd7,
    S_FAULT    = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } apb_phase_t;

endpackage

// File: rtl/bldc_ramp_sequencer_if.sv
// bldc_ramp_sequencer_if: APB2 bus bundle between the sequencer (master)
// and the BLDC peripheral (slave).
//   master drives paddr/psel/penable/pwrite/pwdata/pstrb/pprot,
//   slave drives prdata/pready/pslverr.
interface bldc_ramp_sequencer_if #(
  parameter int addr_width = 8,
  parameter int data_width = 32
);
  logic [addr_width-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [data_width-1:0]   pwdata;
  logic [data_width/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [data_width-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/bldc_ramp_sequencer_apb2_master_port.sv
// apb2_master_port: single-transfer APB2 master engine.
//   pclk, preset_n       : clock, async active-low reset
//   req/we/addr/wdata    : start a transfer (accepted only while idle)
//   done/err/rdata       : one-cycle pulse in the cycle after completion;
//                          err mirrors pslverr, rdata captured on the
//                          completing edge
//   timeout              : one-cycle pulse after timeout_cycles ACCESS
//                          cycles without pready; the transfer is dropped
//   apb                  : APB2 master modport, all outputs registered
module apb2_master_port
  import bldc_seq_pkg::*;
#(
  parameter int addr_width     = 8,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 64
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic                  done,
  output logic [data_width-1:0] rdata,
  output logic                  err,
  output logic                  timeout,
  bldc_ramp_sequencer_if.master apb
);

  localparam int CNT_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);
  localparam int STRB_W = data_width / 8;

  apb_phase_t            phase_q, phase_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [addr_width-1:0] paddr_q, paddr_d;
  logic [data_width-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic [data_width-1:0] rdata_q, rdata_d;

  always_comb begin
    phase_d   = phase_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;

    case (phase_q)
      PH_IDLE: begin
        if (req) begin
          paddr_d  = addr;
          pwrite_d = we;
          pwdata_d = wdata;
          pstrb_d  = we ? '1 : '0;
          psel_d   = 1'b1;
          phase_d  = PH_SETUP;
        end
      end
      PH_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        phase_d   = PH_ACCESS;
      end
      PH_ACCESS: begin
        if (apb.pready) begin
          done_d  = 1'b1;
          err_d   = apb.pslverr;
          rdata_d = apb.prdata;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Address/data are left holding; only the strobes and handshake drop.
        if (apb.pready || cnt_q == CNT_LAST) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pstrb_d   = '0;
          phase_d   = PH_IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pstrb_d   = '0;
        phase_d   = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      phase_q   <= PH_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.pprot   = 3'b000;

  assign done    = done_q;
  assign err     = err_q;
  assign timeout = timeout_q;
  assign rdata   = rdata_q;

endmodule

// File: rtl/bldc_ramp_sequencer.sv
// bldc_ramp_sequencer: APB2 master sequencing a BLDC peripheral through
// start-up, duty ramp, steady run, stop and fault shutdown.
//   pclk, preset_n          : clock, async active-low reset
//   start, stop             : single-cycle commands (stop wins, stop also
//                             clears a latched fault)
//   dir_in                  : direction, captured on an accepted start
//   start_duty, target_duty : first duty / ramp goal (goal sampled per step)
//   apb                     : APB2 master bus
//   cur_duty                : last duty successfully written
//   running, busy, fault    : drive enabled / sequence active / latched fault
//   fault_code              : bit0 status fault, bit1 pslverr, bit2 timeout
module bldc_ramp_sequencer
  import bldc_seq_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int addr_width     = 8,
  parameter int duty_width     = 16,
  parameter int step_interval  = 5400,
  parameter int duty_step      = 1,
  parameter int timeout_cycles = 64
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            dir_in,
  input  logic [duty_width-1:0] start_duty,
  input  logic [duty_width-1:0] target_duty,
  bldc_ramp_sequencer_if.master apb,
  output logic [duty_width-1:0] cur_duty,
  output logic                  running,
  output logic                  busy,
  output logic                  fault,
  output logic [2:0]            fault_code
);

  localparam int TMR_W = (step_interval > 1) ? $clog2(step_interval) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(step_interval - 1);
  localparam logic [duty_width:0] STEP_EXT = (duty_width + 1)'(duty_step);

  seq_state_t            state_q, state_d;
  logic [1:0]            dir_q, dir_d;
  logic [duty_width-1:0] cur_duty_q, cur_duty_d;
  logic [duty_width-1:0] wr_duty_q, wr_duty_d;
  logic                  running_q, running_d;
  logic                  fault_q, fault_d;
  logic [2:0]            fault_code_q, fault_code_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  fault_sd_q, fault_sd_d;  // shutdown caused by an error
  logic [TMR_W-1:0]      timer_q, timer_d;

  // Engine handshake
  logic                  req, req_we;
  logic [addr_width-1:0] req_addr;
  logic [data_width-1:0] req_wdata;
  logic                  xfer_done, xfer_err, xfer_tmo;
  logic [data_width-1:0] xfer_rdata;

  logic                  xfer_end, xfer_bad;
  logic [2:0]            bad_code;
  logic [duty_width:0]   cur_ext, tgt_ext, up_sum, dn_diff;
  logic [duty_width-1:0] next_duty;

  // Next ramp value, computed one bit wider so it saturates at the target
  // instead of wrapping at zero or full scale.
  always_comb begin
    cur_ext = {1'b0, cur_duty_q};
    tgt_ext = {1'b0, target_duty};
    up_sum  = cur_ext + STEP_EXT;
    dn_diff = cur_ext - STEP_EXT;
    if (tgt_ext > cur_ext) begin
      next_duty = (up_sum > tgt_ext) ? target_duty : up_sum[duty_width-1:0];
    end else begin
      next_duty = (STEP_EXT > cur_ext || dn_diff < tgt_ext) ? target_duty
                                                             : dn_diff[duty_width-1:0];
    end
  end

  assign xfer_end = xfer_done | xfer_tmo;
  assign xfer_bad = (xfer_done & xfer_err) | xfer_tmo;
  assign bad_code = {xfer_tmo, xfer_done & xfer_err, 1'b0};

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    cur_duty_d   = cur_duty_q;
    wr_duty_d    = wr_duty_q;
    running_d    = running_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    stop_pend_d  = stop_pend_q;
    fault_sd_d   = fault_sd_q;
    timer_d      = '0;
    req          = 1'b0;
    req_we       = 1'b1;
    req_addr     = addr_width'(REG_PWM);
    req_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          dir_d      = dir_in;
          fault_sd_d = 1'b0;
          state_d    = S_WR_DUTY0;
        end
      end

      S_WR_DUTY0, S_WR_EN, S_RD_STAT, S_WR_STEP: begin
        stop_pend_d = stop_pend_q | stop;
        if (xfer_end) begin
          if (xfer_bad) begin
            fault_code_d = fault_code_q | bad_code;
            fault_sd_d   = 1'b1;
            state_d      = S_SD_DUTY;
          end else begin
            case (state_q)
              S_WR_DUTY0: begin
                cur_duty_d = wr_duty_q;
                state_d    = S_WR_EN;
              end
              S_WR_EN: begin
                running_d = 1'b1;
                state_d   = S_WAIT;
              end
              S_WR_STEP: begin
                cur_duty_d = wr_duty_q;
                state_d    = S_WAIT;
              end
              default: begin
                if (xfer_rdata[STAT_HALL_BIT] || xfer_rdata[STAT_FAULT_BIT]) begin
                  fault_code_d[FC_STATUS] = 1'b1;
                  fault_sd_d              = 1'b1;
                  state_d                 = S_SD_DUTY;
                end else if (cur_duty_q != target_duty) begin
                  state_d = S_WR_STEP;
                end else begin
                  state_d = S_WAIT;
                end
              end
            endcase
            // A stop seen during (or at the end of) the transfer takes over.
            if (stop_pend_q || stop) begin
              state_d = S_SD_DUTY;
            end
          end
        end
      end

      S_WAIT: begin
        if (stop || stop_pend_q) begin
          state_d = S_SD_DUTY;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_RD_STAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_SD_DUTY: begin
        if (xfer_end) begin
          if (xfer_bad) begin
            fault_code_d = fault_code_q | bad_code;
            fault_sd_d   = 1'b1;
          end else begin
            cur_duty_d = '0;
          end
          state_d = S_SD_CTL;
        end
      end

      S_SD_CTL: begin
        if (xfer_end) begin
          running_d = 1'b0;
          if (xfer_bad) begin
            fault_code_d = fault_code_q | bad_code;
          end
          if (fault_sd_q || xfer_bad) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_FAULT: begin
        if (stop) begin
          fault_d      = 1'b0;
          fault_code_d = '0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_SD_DUTY) begin
      stop_pend_d = 1'b0;
    end

    // Every transfer state performs exactly one access, so a transfer is
    // issued on the edge that enters the state; this gives the one-cycle
    // start-to-psel latency and keeps the engine from seeing a request
    // while it is still busy.
    if (state_d != state_q) begin
      case (state_d)
        S_WR_DUTY0: begin
          req       = 1'b1;
          wr_duty_d = start_duty;
          req_wdata = data_width'(start_duty);
        end
        S_WR_EN: begin
          req       = 1'b1;
          req_addr  = addr_width'(REG_CTRL);
          req_wdata = data_width'({dir_q, 1'b1});
        end
        S_RD_STAT: begin
          req      = 1'b1;
          req_we   = 1'b0;
          req_addr = addr_width'(REG_STATUS);
        end
        S_WR_STEP: begin
          req       = 1'b1;
          wr_duty_d = next_duty;
          req_wdata = data_width'(next_duty);
        end
        S_SD_DUTY: begin
          req = 1'b1;
        end
        S_SD_CTL: begin
          req      = 1'b1;
          req_addr = addr_width'(REG_CTRL);
        end
        default: req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q      <= S_IDLE;
      dir_q        <= '0;
      cur_duty_q   <= '0;
      wr_duty_q    <= '0;
      running_q    <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= '0;
      stop_pend_q  <= 1'b0;
      fault_sd_q   <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      cur_duty_q   <= cur_duty_d;
      wr_duty_q    <= wr_duty_d;
      running_q    <= running_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      stop_pend_q  <= stop_pend_d;
      fault_sd_q   <= fault_sd_d;
      timer_q      <= timer_d;
    end
  end

  apb2_master_port #(
    .addr_width     (addr_width),
    .data_width     (data_width),
    .timeout_cycles (timeout_cycles)
  ) u_port (
    .pclk     (pclk),
    .preset_n (preset_n),
    .req      (req),
    .we       (req_we),
    .addr     (req_addr),
    .wdata    (req_wdata),
    .done     (xfer_done),
    .rdata    (xfer_rdata),
    .err      (xfer_err),
    .timeout  (xfer_tmo),
    .apb      (apb)
  );

  assign cur_duty   = cur_duty_q;
  assign running    = running_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);

endmodule
